lfsr_gen: RTL and testbench

Parametrised Fibonacci LFSR pseudo-random source, the next generation of the team's fixed 10-bit LFSR. Adds the following over it:
- configurable width, tap mask, seed and steps-per-transfer;
- runtime reseeding with all-zero lock-up protection;
- a valid/ready output handshake;
- a period-wrap indicator.

It feeds test-pattern generators and scramblers that consume one random word per accepted transfer.

---
 rtl/lfsr_pkg.sv | 26 ++
 rtl/lfsr_gen_if.sv | 26 ++
 rtl/lfsr_step.sv | 27 ++
 rtl/lfsr_gen.sv | 95 +++++++++
 tb/tb_lfsr_gen.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types, feedback helper and reference tap masks for the LFSR family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lfsr_pkg;

   // Generator FSM: LOAD presents a freshly loaded seed with out_valid low.
   // RUN offers words to the consumer.
   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } lfsr_state_e;

   // Maximal-length Fibonacci tap masks. Bit i set means state bit i feeds the XOR.
   localparam logic [3:0]  TAPS_W4  = 4'h9;          // x^4+x^3+1
   localparam logic [7:0]  TAPS_W8  = 8'hB8;         // x^8+x^6+x^5+x^4+1
   localparam logic [9:0]  TAPS_W10 = 10'h240;       // x^10+x^7+1
   localparam logic [15:0] TAPS_W16 = 16'hB400;      // x^16+x^14+x^13+x^11+1
   localparam logic [31:0] TAPS_W32 = 32'h8020_0003; // x^32+x^22+x^2+x+1

   // Feedback bit: parity of the state bits that are selected by the mask.
   // Callers narrower than 32 bits zero-extend both arguments.
   function automatic logic parity_fb(input logic [31:0] state, input logic [31:0] mask);
      return ^(state & mask);
   endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: groups the generator's reseed inputs and its valid/ready word output.
// Ports: seed_load/seed_in (reseed), out_ready (consumer), out_valid/rnd/wrap/lockup (generator).
// Backpressure: rnd is held while out_valid && !out_ready.
interface lfsr_gen_if #(
   parameter int WIDTH = 10
);
   logic             seed_load;
   logic [WIDTH-1:0] seed_in;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] rnd;
   logic             wrap;
   logic             lockup;

   // The master side is the generator.
   modport master (
      input  seed_load, seed_in, out_ready,
      output out_valid, rnd, wrap, lockup
   );

   // The slave side is the consumer/controller.
   modport slave (
      output seed_load, seed_in, out_ready,
      input  out_valid, rnd, wrap, lockup
   );
endinterface

// File: rtl/lfsr_step.sv
// lfsr_step: combinational STEPS-fold composition of a single Fibonacci LFSR shift.
// Ports: state_in (current state) -> state_out (state after STEPS shifts). Latency: 0 cycles.
// Backpressure: none; a pure function of state_in.
module lfsr_step
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 10,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W10),
   parameter int               STEPS = 1
) (
   input  logic [WIDTH-1:0] state_in,
   output logic [WIDTH-1:0] state_out
);

   logic [WIDTH-1:0] s;

   // Each iteration shifts left and inserts the feedback bit at the LSB.
   // The loop unrolls into STEPS cascaded XOR stages.
   always_comb begin
      s = state_in;
      for (int i = 0; i < STEPS; i++) begin
         s = {s[WIDTH-2:0], parity_fb(32'(s), 32'(TAPS))};
      end
      state_out = s;
   end

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci LFSR random-word source with reseed, lock-up guard and period-wrap flag.
// Ports: clk, rst (async, active-high), bus (lfsr_gen_if.master). Latency: 1 cycle transfer-to-next-word.
// Backpressure: rnd and out_valid are held while out_ready is low. A reseed costs one invalid cycle.
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 10,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W10),
   parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}},
   parameter int               STEPS = 1
) (
   input  logic       clk,
   input  logic       rst,
   lfsr_gen_if.master bus
);

   lfsr_state_e      state_q, state_d;
   logic [WIDTH-1:0] rnd_q, rnd_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic             wrap_q, wrap_d;
   logic             lockup_q, lockup_d;

   logic [WIDTH-1:0] adv_state;
   logic [WIDTH-1:0] load_val;
   logic             seed_zero;

   lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .STEPS (STEPS)
   ) u_step (
      .state_in  (rnd_q),
      .state_out (adv_state)
   );

   // An all-zero state would lock the LFSR forever, so a zero load is replaced by SEED.
   assign seed_zero = (bus.seed_in == '0);
   assign load_val  = seed_zero ? SEED : bus.seed_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_LOAD;
         rnd_q    <= SEED;
         seed_q   <= SEED;
         wrap_q   <= 1'b0;
         lockup_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rnd_q    <= rnd_d;
         seed_q   <= seed_d;
         wrap_q   <= wrap_d;
         lockup_q <= lockup_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rnd_d    = rnd_q;
      seed_d   = seed_q;
      wrap_d   = 1'b0;
      lockup_d = 1'b0;

      if (bus.seed_load) begin
         // A reseed overrides any transfer in the same cycle. The advance is
         // dropped and no wrap is reported.
         seed_d   = load_val;
         rnd_d    = load_val;
         lockup_d = seed_zero;
         state_d  = ST_LOAD;
      end else begin
         unique case (state_q)
            ST_LOAD: begin
               state_d = ST_RUN;
            end
            ST_RUN: begin
               if (bus.out_ready) begin
                  rnd_d  = adv_state;
                  // Returning to the active seed marks the end of one period.
                  wrap_d = (adv_state == seed_q);
               end
            end
            default: begin
               state_d = ST_LOAD;
            end
         endcase
      end
   end

   // All outputs come straight from flops. out_valid is the RUN state bit.
   assign bus.out_valid = (state_q == ST_RUN);
   assign bus.rnd       = rnd_q;
   assign bus.wrap      = wrap_q;
   assign bus.lockup    = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed bench for lfsr_gen in three configurations (default, 4-bit, STEPS=2).
// Latency: n/a.
// Backpressure: exercised by holding out_ready low on the default instance.
module tb_lfsr_gen;

   logic clk;
   logic rst;

   int n_total = 0;
   int n_pass  = 0;

   lfsr_gen_if #(.WIDTH(10)) ifa ();
   lfsr_gen_if #(.WIDTH(4))  ifb ();
   lfsr_gen_if #(.WIDTH(10)) ifc ();

   lfsr_gen #(.WIDTH(10)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.master)
   );

   lfsr_gen #(.WIDTH(4), .TAPS(4'b1001), .SEED(4'hF), .STEPS(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.master)
   );

   lfsr_gen #(.WIDTH(10), .STEPS(2)) dut_c (
      .clk (clk),
      .rst (rst),
      .bus (ifc.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       ld;
      logic [3:0] sd;
      logic       rdy;
      logic       e_vld;
      logic [3:0] e_rnd;
      logic       e_wrap;
      logic       e_lock;
   } vec_t;

   function automatic vec_t mkv(logic ld, logic [3:0] sd, logic rdy,
                                logic vld, logic [3:0] r, logic w, logic lk);
      vec_t v;
      v.ld     = ld;
      v.sd     = sd;
      v.rdy    = rdy;
      v.e_vld  = vld;
      v.e_rnd  = r;
      v.e_wrap = w;
      v.e_lock = lk;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change and outputs are sampled 2 time units after each rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   vec_t       vq[$];
   logic [3:0] seq4 [14];
   logic [9:0] hold_val;
   int         early_wraps;

   initial begin
      rst = 1'b1;
      ifa.seed_load = 1'b0; ifa.seed_in = '0; ifa.out_ready = 1'b0;
      ifb.seed_load = 1'b0; ifb.seed_in = '0; ifb.out_ready = 1'b0;
      ifc.seed_load = 1'b0; ifc.seed_in = '0; ifc.out_ready = 1'b0;

      // Reset state
      #3;
      chk("rst_a_rnd",    32'(ifa.rnd),       32'h3FF);
      chk("rst_a_valid",  32'(ifa.out_valid), 32'h0);
      chk("rst_a_wrap",   32'(ifa.wrap),      32'h0);
      chk("rst_a_lockup", 32'(ifa.lockup),    32'h0);
      chk("rst_b_rnd",    32'(ifb.rnd),       32'hF);
      chk("rst_c_rnd",    32'(ifc.rnd),       32'h3FF);

      // Default instance: first word, then one word per cycle
      @(posedge clk); #2;
      rst = 1'b0;
      ifa.out_ready = 1'b1;
      step();
      chk("a_first_valid", 32'(ifa.out_valid), 32'h1);
      chk("a_first_rnd",   32'(ifa.rnd),       32'h3FF);
      step();
      chk("a_second_rnd",  32'(ifa.rnd),       32'h3FE);
      step();
      chk("a_third_rnd",   32'(ifa.rnd),       32'h3FC);

      // Two transfers are done. Run to transfer number 1023.
      early_wraps = 0;
      for (int k = 3; k <= 1023; k++) begin
         step();
         if (k < 1023 && ifa.wrap) early_wraps++;
      end
      chk("a_early_wraps", 32'(early_wraps), 32'h0);
      chk("a_period_wrap", 32'(ifa.wrap),    32'h1);
      chk("a_period_rnd",  32'(ifa.rnd),     32'h3FF);
      step();
      chk("a_wrap_cleared", 32'(ifa.wrap), 32'h0);
      chk("a_after_wrap",   32'(ifa.rnd),  32'h3FE);

      // Backpressure holds the word and out_valid
      ifa.out_ready = 1'b0;
      hold_val = ifa.rnd;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("a_bp_rnd",   32'(ifa.rnd),       32'h3FE);
         chk("a_bp_valid", 32'(ifa.out_valid), 32'h1);
      end
      ifa.out_ready = 1'b1;
      step();
      chk("a_release1", 32'(ifa.rnd), 32'h3FC);
      step();
      chk("a_release2", 32'(ifa.rnd), 32'h3F8);

      // Asynchronous reset mid-stream
      #1 rst = 1'b1;
      #1;
      chk("a_midrst_rnd",   32'(ifa.rnd),       32'h3FF);
      chk("a_midrst_valid", 32'(ifa.out_valid), 32'h0);
      ifc.out_ready = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      step();
      chk("a_restart_valid", 32'(ifa.out_valid), 32'h1);
      chk("a_restart_rnd",   32'(ifa.rnd),       32'h3FF);
      chk("c_first_rnd",     32'(ifc.rnd),       32'h3FF);
      step();
      chk("a_restart_rnd2",  32'(ifa.rnd),       32'h3FE);
      chk("c_second_rnd",    32'(ifc.rnd),       32'h3FC);
      step();
      chk("c_third_rnd",     32'(ifc.rnd),       32'h3F0);

      // 4-bit instance: vector table
      seq4 = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
               4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};
      vq.push_back(mkv(1'b1, 4'h1, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0)); // load 1
      vq.push_back(mkv(1'b0, 4'h0, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0)); // RUN, first word
      for (int i = 0; i < 14; i++)
         vq.push_back(mkv(1'b0, 4'h0, 1'b1, 1'b1, seq4[i], 1'b0, 1'b0));
      vq.push_back(mkv(1'b0, 4'h0, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0)); // 8 -> 1 wraps
      vq.push_back(mkv(1'b0, 4'h0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0)); // stall
      vq.push_back(mkv(1'b1, 4'h0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1)); // zero load + transfer
      vq.push_back(mkv(1'b0, 4'h0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0)); // RUN at SEED
      vq.push_back(mkv(1'b0, 4'h0, 1'b1, 1'b1, 4'hE, 1'b0, 1'b0)); // F -> E
      vq.push_back(mkv(1'b1, 4'h5, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0)); // load 5
      vq.push_back(mkv(1'b1, 4'hA, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0)); // reload while in LOAD
      vq.push_back(mkv(1'b0, 4'h0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0)); // RUN
      vq.push_back(mkv(1'b0, 4'h0, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0)); // A -> 5

      foreach (vq[i]) begin
         ifb.seed_load = vq[i].ld;
         ifb.seed_in   = vq[i].sd;
         ifb.out_ready = vq[i].rdy;
         step();
         chk($sformatf("b_v%0d_valid", i),  32'(ifb.out_valid), 32'(vq[i].e_vld));
         chk($sformatf("b_v%0d_rnd", i),    32'(ifb.rnd),       32'(vq[i].e_rnd));
         chk($sformatf("b_v%0d_wrap", i),   32'(ifb.wrap),      32'(vq[i].e_wrap));
         chk($sformatf("b_v%0d_lockup", i), 32'(ifb.lockup),    32'(vq[i].e_lock));
      end

      // A reset arriving while a lockup pulse is up clears the pulse immediately
      ifb.seed_load = 1'b1;
      ifb.seed_in   = 4'h0;
      ifb.out_ready = 1'b0;
      step();
      ifb.seed_load = 1'b0;
      chk("b_lockup_pulse", 32'(ifb.lockup), 32'h1);
      #1 rst = 1'b1;
      #1;
      chk("b_rst_lockup", 32'(ifb.lockup),    32'h0);
      chk("b_rst_valid",  32'(ifb.out_valid), 32'h0);
      chk("b_rst_rnd",    32'(ifb.rnd),       32'hF);
      @(posedge clk); #2;
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
